// File: rtl/hw_stack_pkg.sv
// Shared constants, operation encoding and width helper for the hw_stack block.
package hw_stack_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultDepth = 128;

    typedef enum logic [2:0] {
        OpNone,
        OpClear,
        OpPush,
        OpPop,
        OpReplace,
        OpPushUnder,
        OpOverflow,
        OpUnderflow
    } stack_op_e;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: synchronous write, asynchronous read, no reset on the array.
module stack_ram #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/hw_stack.sv
// LIFO stack with registered pop data and sticky error flags.
// Define HW_STACK_WATERMARK_EN to add the hwm (high-water mark) output.
module hw_stack
    import hw_stack_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth,
    localparam int unsigned AW   = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_d,
    output logic [WIDTH-1:0] pop_d,
    output logic             pop_valid,
    output logic [WIDTH-1:0] top_d,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
`ifdef HW_STACK_WATERMARK_EN
    ,
    output logic [AW:0]      hwm
`endif
);

    localparam logic [AW:0] CountOne = (AW + 1)'(1);
    localparam logic [AW:0] CountMax = (AW + 1)'(DEPTH);

    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] pop_d_q, pop_d_d;
    logic             pop_valid_q, pop_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    stack_op_e        op;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    top_addr;
    logic [WIDTH-1:0] rdata;

    assign full     = (count_q == CountMax);
    assign empty    = (count_q == '0);
    // Wraps to DEPTH-1 when full, which is exactly the top slot.
    assign top_addr = count_q[AW-1:0] - AW'(1);

    always_comb begin
        op = OpNone;
        if (clear) begin
            op = OpClear;
        end else if (push && pop) begin
            op = empty ? OpPushUnder : OpReplace;
        end else if (push) begin
            op = full ? OpOverflow : OpPush;
        end else if (pop) begin
            op = empty ? OpUnderflow : OpPop;
        end
    end

    always_comb begin
        count_d     = count_q;
        pop_d_d     = pop_d_q;
        pop_valid_d = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        we          = 1'b0;
        waddr       = count_q[AW-1:0];
        unique case (op)
            OpNone: ;
            OpClear: begin
                count_d     = '0;
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
            OpPush: begin
                we      = 1'b1;
                count_d = count_q + CountOne;
            end
            OpPushUnder: begin
                we          = 1'b1;
                count_d     = count_q + CountOne;
                underflow_d = 1'b1;
            end
            OpPop: begin
                pop_d_d     = rdata;
                pop_valid_d = 1'b1;
                count_d     = count_q - CountOne;
            end
            OpReplace: begin
                pop_d_d     = rdata;
                pop_valid_d = 1'b1;
                we          = 1'b1;
                waddr       = top_addr;
            end
            OpOverflow:  overflow_d  = 1'b1;
            OpUnderflow: underflow_d = 1'b1;
            default: ;
        endcase
    end

`ifdef HW_STACK_WATERMARK_EN
    logic [AW:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (clear) begin
            hwm_d = '0;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
    end

    assign hwm = hwm_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            pop_d_q     <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`ifdef HW_STACK_WATERMARK_EN
            hwm_q       <= '0;
`endif
        end else begin
            count_q     <= count_d;
            pop_d_q     <= pop_d_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
`ifdef HW_STACK_WATERMARK_EN
            hwm_q       <= hwm_d;
`endif
        end
    end

    // Reset held across an edge must not let a pending push land in storage.
    stack_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .we   (we && !reset),
        .waddr(waddr),
        .wdata(push_d),
        .raddr(top_addr),
        .rdata(rdata)
    );

    assign top_d     = empty ? '0 : rdata;
    assign pop_d     = pop_d_q;
    assign pop_valid = pop_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_hw_stack.sv
// Self-checking bench for hw_stack (DEPTH=4) against a queue-based reference model.
module tb_hw_stack;

    localparam int unsigned W  = 16;
    localparam int unsigned D  = 4;
    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [W-1:0]  push_d = '0;
    logic [W-1:0]  pop_d;
    logic          pop_valid;
    logic [W-1:0]  top_d;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
`ifdef HW_STACK_WATERMARK_EN
    logic [AW:0]   hwm;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [W-1:0] mq[$];
    logic [W-1:0] m_pop_d;
    logic         m_pv;
    logic         m_of;
    logic         m_uf;
    int unsigned  m_hwm;

    hw_stack #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .push     (push),
        .pop      (pop),
        .push_d   (push_d),
        .pop_d    (pop_d),
        .pop_valid(pop_valid),
        .top_d    (top_d),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
`ifdef HW_STACK_WATERMARK_EN
        ,
        .hwm      (hwm)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pop_d = '0;
        m_pv    = 1'b0;
        m_of    = 1'b0;
        m_uf    = 1'b0;
        m_hwm   = 0;
    endtask

    task automatic model_step(input logic p, input logic o, input logic c, input logic [W-1:0] d);
        m_pv = 1'b0;
        if (c) begin
            mq.delete();
            m_of  = 1'b0;
            m_uf  = 1'b0;
            m_hwm = 0;
        end else begin
            if (p && o) begin
                if (mq.size() == 0) begin
                    mq.push_back(d);
                    m_uf = 1'b1;
                end else begin
                    m_pop_d = mq.pop_back();
                    mq.push_back(d);
                    m_pv = 1'b1;
                end
            end else if (p) begin
                if (mq.size() == D) m_of = 1'b1;
                else mq.push_back(d);
            end else if (o) begin
                if (mq.size() == 0) m_uf = 1'b1;
                else begin
                    m_pop_d = mq.pop_back();
                    m_pv = 1'b1;
                end
            end
            if (mq.size() > m_hwm) m_hwm = mq.size();
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] exp_top;
        exp_top = (mq.size() == 0) ? '0 : mq[$];
        chk(tag, "count", 64'(count), 64'(mq.size()));
        chk(tag, "empty", 64'(empty), 64'(mq.size() == 0));
        chk(tag, "full", 64'(full), 64'(mq.size() == D));
        chk(tag, "top_d", 64'(top_d), 64'(exp_top));
        chk(tag, "pop_d", 64'(pop_d), 64'(m_pop_d));
        chk(tag, "pop_valid", 64'(pop_valid), 64'(m_pv));
        chk(tag, "overflow", 64'(overflow), 64'(m_of));
        chk(tag, "underflow", 64'(underflow), 64'(m_uf));
`ifdef HW_STACK_WATERMARK_EN
        chk(tag, "hwm", 64'(hwm), 64'(m_hwm));
`endif
    endtask

    // Drive one cycle, advance the model at the edge, check 1 time unit later.
    task automatic step(input string tag, input logic p, input logic o, input logic c,
                        input logic [W-1:0] d);
        push   = p;
        pop    = o;
        clear  = c;
        push_d = d;
        @(posedge clk);
        model_step(p, o, c, d);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset_async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset_state");

        // LIFO order
        step("push1", 1, 0, 0, 16'h1111);
        step("push2", 1, 0, 0, 16'h2222);
        step("push3", 1, 0, 0, 16'h3333);
        chk("lifo", "count3", 64'(count), 64'd3);
        chk("lifo", "top3333", 64'(top_d), 64'h3333);
        step("pop1", 0, 1, 0, '0);
        chk("lifo", "pop3333", 64'(pop_d), 64'h3333);
        step("pop2", 0, 1, 0, '0);
        step("pop3", 0, 1, 0, '0);
        chk("lifo", "pop1111", 64'(pop_d), 64'h1111);
        chk("lifo", "empty", 64'(empty), 64'd1);

        // Underflow on empty, then clear
        step("pop_empty", 0, 1, 0, '0);
        chk("uflow", "flag", 64'(underflow), 64'd1);
        chk("uflow", "pop_d_held", 64'(pop_d), 64'h1111);
        step("idle_sticky", 0, 0, 0, '0);
        step("clear_uf", 0, 0, 1, '0);
        chk("uflow", "cleared", 64'(underflow), 64'd0);

        // Overflow at DEPTH
        for (int i = 0; i < 5; i++) step("fill", 1, 0, 0, W'(16'hA000 + i));
        chk("oflow", "full", 64'(full), 64'd1);
        chk("oflow", "flag", 64'(overflow), 64'd1);
        chk("oflow", "top4th", 64'(top_d), 64'hA003);

        // Replace top, then at full
        step("clear2", 0, 0, 1, '0);
        step("pushA", 1, 0, 0, 16'h1234);
        step("pushB", 1, 0, 0, 16'hAAAA);
        step("replace", 1, 1, 0, 16'hBBBB);
        chk("repl", "pop_d", 64'(pop_d), 64'hAAAA);
        chk("repl", "top", 64'(top_d), 64'hBBBB);
        step("fillC", 1, 0, 0, 16'hCCCC);
        step("fillD", 1, 0, 0, 16'hDDDD);
        step("repl_full", 1, 1, 0, 16'hEEEE);
        chk("repl", "no_oflow", 64'(overflow), 64'd0);
        chk("repl", "pop_full", 64'(pop_d), 64'hDDDD);

        // Push+pop on empty: push accepted, underflow set
        step("clear3", 0, 0, 1, '0);
        step("pp_empty", 1, 1, 0, 16'h5A5A);

        // Watermark pattern
        step("clear4", 0, 0, 1, '0);
        for (int i = 0; i < 3; i++) step("wm_push", 1, 0, 0, W'(16'h0100 + i));
        step("wm_pop", 0, 1, 0, '0);
        step("wm_pop", 0, 1, 0, '0);
        step("wm_push1", 1, 0, 0, 16'h0F0F);
        step("wm_clear", 0, 0, 1, '0);

        // Asynchronous reset mid-cycle with a push pending
        for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, 0, W'(16'h7700 + i));
        push   = 1'b1;
        push_d = 16'hDEAD;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("rst_mid");
        @(posedge clk);
        #1;
        check_all("rst_edge");
        reset = 1'b0;
        push  = 1'b0;
        step("post_rst_idle", 0, 0, 0, '0);

        // Clear wins over push
        step("pre_clr", 1, 0, 0, 16'h4444);
        step("clr_push", 1, 0, 1, 16'h5555);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic rp, ro, rc;
            rp = 1'($urandom_range(0, 1));
            ro = 1'($urandom_range(0, 1));
            rc = ($urandom_range(0, 31) == 0);
            step("rand", rp, ro, rc, W'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
